// File: rtl/rtc_pkg.sv
// Shared constants, address map and FSM types for the RTC register
// scheduler and its storage bank.
package rtc_pkg;

   localparam int NUM_REGS   = 10;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;

   localparam logic [ADDR_WIDTH-1:0] A_TIME_LO  = 4'd0;
   localparam logic [ADDR_WIDTH-1:0] A_TIME_HI  = 4'd2;
   localparam logic [ADDR_WIDTH-1:0] A_DATE_LO  = 4'd3;
   localparam logic [ADDR_WIDTH-1:0] A_DATE_HI  = 4'd5;
   localparam logic [ADDR_WIDTH-1:0] A_TIMER_LO = 4'd6;
   localparam logic [ADDR_WIDTH-1:0] A_TIMER_HI = 4'd8;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL     = 4'd9;

   localparam int GRP_TIME  = 0;
   localparam int GRP_DATE  = 1;
   localparam int GRP_TIMER = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_BLANK,
      S_WRITE,
      S_ACK
   } state_e;

   typedef enum logic {
      SRC_RTC,
      SRC_ED
   } src_e;

   // Control register and out-of-range addresses belong to no group.
   function automatic logic [2:0] grp_of(input logic [ADDR_WIDTH-1:0] a);
      logic [2:0] g;
      g = 3'b000;
      if (a <= A_TIME_HI)
         g[GRP_TIME] = 1'b1;
      else if (a >= A_DATE_LO && a <= A_DATE_HI)
         g[GRP_DATE] = 1'b1;
      else if (a >= A_TIMER_LO && a <= A_TIMER_HI)
         g[GRP_TIMER] = 1'b1;
      return g;
   endfunction

endpackage

// File: rtl/rtc_reg_bank.sv
// RTC register storage: one write port, one registered read port that
// returns zero for addresses beyond the bank.
module rtc_reg_bank
   import rtc_pkg::*;
#(
   parameter int NUM_REGS   = rtc_pkg::NUM_REGS,
   parameter int DATA_WIDTH = rtc_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  wr_ok;
   logic                  rd_ok;

   assign wr_ok   = we_i && (int'(waddr_i) < NUM_REGS);
   assign rd_ok   = int'(raddr_i) < NUM_REGS;
   assign rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem_q[i] <= '0;
      end else if (wr_ok) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Reads see the array before this edge's write: no bypass.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni)
         rdata_q <= '0;
      else
         rdata_q <= rd_ok ? mem_q[raddr_i] : '0;
   end

endmodule

// File: rtl/rtc_reg_sched.sv
// RTC register scheduler: arbitrates RTC readback and user edits into
// the register bank, deferring each write to display blanking.
module rtc_reg_sched
   import rtc_pkg::*;
#(
   parameter int NUM_REGS   = rtc_pkg::NUM_REGS,
   parameter int DATA_WIDTH = rtc_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  v_sync,
   input  logic                  rtc_req,
   input  logic [ADDR_WIDTH-1:0] rtc_addr,
   input  logic [DATA_WIDTH-1:0] rtc_data,
   output logic                  rtc_ack,
   input  logic                  ed_req,
   input  logic [ADDR_WIDTH-1:0] ed_addr,
   input  logic [DATA_WIDTH-1:0] ed_data,
   output logic                  ed_ack,
   output logic                  err,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic [DATA_WIDTH-1:0] disp_data,
   output logic [2:0]            upd_flags
);

   state_e                state_q;
   src_e                  win_q;
   src_e                  last_q;
   src_e                  pick;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  rtc_ack_q;
   logic                  ed_ack_q;
   logic                  err_q;
   logic                  vs_q;
   logic [2:0]            flags_q;
   logic [2:0]            flags_d;
   logic                  any_req;
   logic                  addr_ok;
   logic                  we;
   logic                  vs_rise;

   assign any_req = rtc_req | ed_req;
   assign addr_ok = int'(addr_q) < NUM_REGS;
   assign we      = (state_q == S_WRITE) && addr_ok;
   assign vs_rise = v_sync & ~vs_q;

   assign rtc_ack   = rtc_ack_q;
   assign ed_ack    = ed_ack_q;
   assign err       = err_q;
   assign upd_flags = flags_q;

   // On a tie the requester not served last wins.
   always_comb begin
      pick = ed_req ? SRC_ED : SRC_RTC;
      if (rtc_req && ed_req)
         pick = (last_q == SRC_RTC) ? SRC_ED : SRC_RTC;
   end

   // A write in the frame-start cycle keeps its group bit.
   always_comb begin
      flags_d = vs_rise ? 3'b000 : flags_q;
      if (we)
         flags_d = flags_d | grp_of(addr_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         win_q     <= SRC_RTC;
         last_q    <= SRC_RTC;
         addr_q    <= '0;
         data_q    <= '0;
         rtc_ack_q <= 1'b0;
         ed_ack_q  <= 1'b0;
         err_q     <= 1'b0;
         vs_q      <= 1'b1;
         flags_q   <= 3'b000;
      end else begin
         rtc_ack_q <= 1'b0;
         ed_ack_q  <= 1'b0;
         err_q     <= 1'b0;
         vs_q      <= v_sync;
         flags_q   <= flags_d;
         unique case (state_q)
            S_IDLE: begin
               if (any_req)
                  state_q <= S_GRANT;
            end
            S_GRANT: begin
               if (!any_req) begin
                  state_q <= S_IDLE;
               end else begin
                  win_q   <= pick;
                  last_q  <= pick;
                  addr_q  <= (pick == SRC_ED) ? ed_addr : rtc_addr;
                  data_q  <= (pick == SRC_ED) ? ed_data : rtc_data;
                  state_q <= v_sync ? S_WAIT_BLANK : S_WRITE;
               end
            end
            S_WAIT_BLANK: begin
               if (!v_sync)
                  state_q <= S_WRITE;
            end
            S_WRITE: begin
               rtc_ack_q <= (win_q == SRC_RTC);
               ed_ack_q  <= (win_q == SRC_ED);
               err_q     <= ~addr_ok;
               state_q   <= S_ACK;
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   rtc_reg_bank #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bank (
      .clk     (clk),
      .rst_ni  (reset),
      .we_i    (we),
      .waddr_i (addr_q),
      .wdata_i (data_q),
      .raddr_i (disp_addr),
      .rdata_o (disp_data)
   );

endmodule

// File: tb/tb_rtc_reg_sched.sv
// Randomised bench for rtc_reg_sched against a transaction-level
// model of the register bank, update flags and round-robin order.
module tb_rtc_reg_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       v_sync;
   logic       rtc_req;
   logic [3:0] rtc_addr;
   logic [7:0] rtc_data;
   logic       rtc_ack;
   logic       ed_req;
   logic [3:0] ed_addr;
   logic [7:0] ed_data;
   logic       ed_ack;
   logic       err;
   logic [3:0] disp_addr;
   logic [7:0] disp_data;
   logic [2:0] upd_flags;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_bank [16];
   logic [2:0] m_flags;
   bit         m_last_ed;

   always #5 clk = ~clk;

   rtc_reg_sched dut (
      .clk       (clk),
      .reset     (reset),
      .v_sync    (v_sync),
      .rtc_req   (rtc_req),
      .rtc_addr  (rtc_addr),
      .rtc_data  (rtc_data),
      .rtc_ack   (rtc_ack),
      .ed_req    (ed_req),
      .ed_addr   (ed_addr),
      .ed_data   (ed_data),
      .ed_ack    (ed_ack),
      .err       (err),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .upd_flags (upd_flags)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] m_grp(input int a);
      if (a < 3) return 3'b001;
      if (a < 6) return 3'b010;
      if (a < 9) return 3'b100;
      return 3'b000;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
      m_flags   = 3'b000;
      m_last_ed = 1'b0;
   endtask

   task automatic vs_set(input logic v);
      if (v && !v_sync) m_flags = 3'b000;
      v_sync = v;
   endtask

   task automatic frame();
      vs_set(1'b1);
      @(negedge clk);
      chk("frame_clr", upd_flags, m_flags);
      vs_set(1'b0);
      @(negedge clk);
   endtask

   task automatic disp_chk(input int a);
      disp_addr = 4'(a);
      @(negedge clk);
      chk("disp", disp_data, (a < 10) ? m_bank[a] : 8'h00);
   endtask

   task automatic do_txn(input bit use_r, input bit use_e,
                         input int ra, input int rd,
                         input int ea, input int edat,
                         input int hold, input bit rise_wr);
      bit need_r, need_e, w_ed, first, tmo;
      int n, a, d;
      need_r = use_r;
      need_e = use_e;
      first  = 1'b1;
      tmo    = 1'b0;
      rtc_addr = 4'(ra);
      rtc_data = 8'(rd);
      ed_addr  = 4'(ea);
      ed_data  = 8'(edat);
      if (hold > 0) vs_set(1'b1);
      rtc_req = use_r;
      ed_req  = use_e;
      while ((need_r || need_e) && !tmo) begin
         w_ed = (need_r && need_e) ? !m_last_ed : need_e;
         n = 0;
         forever begin
            @(negedge clk);
            n++;
            if (first && hold > 0 && n == hold) vs_set(1'b0);
            if (first && hold == 0 && rise_wr && n == 2) vs_set(1'b1);
            if (rtc_ack || ed_ack || n > 40) break;
         end
         if (n > 40) begin
            chk("ack_timeout", 32'd1, 32'd0);
            tmo = 1'b1;
         end else begin
            a = w_ed ? ea : ra;
            d = w_ed ? edat : rd;
            chk("ack_overlap", 32'(rtc_ack & ed_ack), 32'd0);
            chk("ed_win", 32'(ed_ack), 32'(w_ed));
            chk("err", 32'(err), 32'(a >= 10));
            if (first && hold > 0)
               chk("lat_blank", n, hold + 2);
            else
               chk("lat", n, 3);
            if (a < 10) begin
               m_bank[a] = 8'(d);
               m_flags   = m_flags | m_grp(a);
            end
            m_last_ed = w_ed;
            chk("flags", upd_flags, m_flags);
            if (w_ed) begin
               ed_req = 1'b0;
               need_e = 1'b0;
            end else begin
               rtc_req = 1'b0;
               need_r = 1'b0;
            end
            if (v_sync) vs_set(1'b0);
            @(negedge clk);
            chk("ack_pulse", 32'(rtc_ack | ed_ack | err), 32'd0);
         end
         first = 1'b0;
      end
      rtc_req = 1'b0;
      ed_req  = 1'b0;
      if (v_sync) vs_set(1'b0);
   endtask

   initial begin
      int sel, ra, ea, hold;
      bit rw;
      reset     = 1'b0;
      v_sync    = 1'b0;
      rtc_req   = 1'b0;
      ed_req    = 1'b0;
      rtc_addr  = '0;
      rtc_data  = '0;
      ed_addr   = '0;
      ed_data   = '0;
      disp_addr = '0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_rtc_ack", 32'(rtc_ack), 32'd0);
      chk("rst_ed_ack", 32'(ed_ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_flags", upd_flags, 3'b000);
      chk("rst_disp", disp_data, 8'h00);
      reset = 1'b1;
      @(negedge clk);

      // Tie straight out of reset: edit goes first.
      do_txn(1'b1, 1'b1, 1, 8'h21, 7, 8'h77, 0, 1'b0);
      chk("tie_flags", upd_flags, 3'b101);
      disp_chk(1);
      disp_chk(7);

      frame();
      do_txn(1'b0, 1'b1, 0, 0, 4, 8'h12, 0, 1'b0);
      chk("ed4_flags", upd_flags, 3'b010);
      disp_chk(4);

      frame();
      do_txn(1'b1, 1'b0, 0, 8'h59, 0, 0, 4, 1'b0);
      disp_chk(0);

      do_txn(1'b0, 1'b1, 0, 0, 12, 8'hAA, 0, 1'b0);
      for (int i = 0; i < 16; i++) disp_chk(i);

      frame();
      do_txn(1'b0, 1'b1, 0, 0, 2, 8'h3C, 0, 1'b1);
      chk("rise_wr_flags", upd_flags, 3'b001);
      disp_chk(2);

      // Reset while a write waits for blanking.
      frame();
      vs_set(1'b1);
      rtc_addr = 4'd2;
      rtc_data = 8'h33;
      rtc_req  = 1'b1;
      repeat (4) @(negedge clk);
      chk("wb_no_ack", 32'(rtc_ack | ed_ack), 32'd0);
      reset   = 1'b0;
      rtc_req = 1'b0;
      m_reset();
      @(negedge clk);
      v_sync = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_ack", 32'(rtc_ack | ed_ack), 32'd0);
      end
      for (int i = 0; i < 16; i++) disp_chk(i);
      do_txn(1'b1, 1'b1, 5, 8'h05, 8, 8'h88, 0, 1'b0);

      for (int t = 0; t < 80; t++) begin
         sel = $urandom % 4;
         ra = ($urandom % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
         ea = ($urandom % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
         hold = ($urandom % 3 == 0) ? $urandom_range(1, 5) : 0;
         rw = (hold == 0) && ($urandom % 5 == 0);
         do_txn(sel != 1, sel != 0, ra, $urandom % 256, ea, $urandom % 256, hold, rw);
         disp_chk(ra);
         disp_chk(ea);
         disp_chk($urandom % 16);
         if ($urandom % 6 == 0) frame();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rtc_reg_sched.md
RTC_REG_SCHED -- requirements
Module: rtc_reg_sched

Interface
REQ-001 Parameter: NUM_REGS, default 10, number of 8-bit RTC registers held (addresses 0..NUM_REGS-1).
REQ-002 Parameter: DATA_WIDTH, default 8, register width.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-005 v_sync  in  1  display sync; 0 = blanking window in which bank writes are permitted.
REQ-006 rtc_req / rtc_addr[3:0] / rtc_data[7:0]  in  RTC readback write request, address, data.
REQ-007 rtc_ack  out  1  one-cycle pulse: RTC request serviced.
REQ-008 ed_req / ed_addr[3:0] / ed_data[7:0]  in  user-edit commit request, address, data.
REQ-009 ed_ack  out  1  one-cycle pulse: edit request serviced.
REQ-010 err  out  1  one-cycle pulse coincident with an ack when the serviced address was >= NUM_REGS.
REQ-011 disp_addr[3:0]  in  display read address; disp_data[7:0]  out  registered read data.
REQ-012 upd_flags[2:0]  out  bit0 time (addr 0-2), bit1 date (3-5), bit2 timer (6-8) written since last frame start.

Function
REQ-013 FSM states: IDLE, GRANT, WAIT_BLANK, WRITE, ACK.
REQ-014 IDLE: if rtc_req or ed_req sampled high, go GRANT; else stay.
REQ-015 GRANT: latch winner, its addr and data; go WRITE if v_sync=0, else WAIT_BLANK.
REQ-016 WAIT_BLANK: stay until v_sync=0, then go WRITE.
REQ-017 WRITE: if latched addr < NUM_REGS, bank[addr] <= data; otherwise no write; go ACK unconditionally.
REQ-018 ACK: assert the winner's ack for exactly this cycle (plus err if addr invalid); go IDLE.
REQ-019 Minimum latency: req high at edge N with v_sync=0 -> ack high in cycle N+3.
REQ-020 Arbitration: single requester wins; both requesting -> round-robin, the one not granted last wins; last_grant resets to RTC so edit wins first tie.
REQ-021 Handshake: requester holds req/addr/data stable until ack; drops req the cycle after ack; a still-high req after ACK is a new request.
REQ-022 req dropped after GRANT: latched operation completes and ack still pulses.
REQ-023 v_sync rising during WRITE: write completes atomically; no abort.
REQ-024 disp_data <= bank[disp_addr] each cycle (1-cycle latency); disp_addr >= NUM_REGS returns 0x00; a WRITE to the read address updates disp_data one cycle later (write-then-read, no bypass).
REQ-025 upd_flags bit set in the WRITE cycle for its address group; addr 9 sets none; all bits clear on v_sync rising edge (registered edge detect); set wins over simultaneous clear.
REQ-026 rtc_ack and ed_ack never high in the same cycle.

Reset
REQ-027 On reset=0: state IDLE, bank all 0x00, disp_data 0x00, rtc_ack/ed_ack/err 0, upd_flags 0, last_grant RTC, v_sync edge register 1.
REQ-028 Reset during any state abandons the pending operation with no write and no ack.

Structure
REQ-029 Shared package rtc_pkg holds NUM_REGS, address constants (time 0-2, date 3-5, timer 6-8, control 9), group mapping, and the FSM state enum.
REQ-030 Storage is a sub-module rtc_reg_bank (NUM_REGS x DATA_WIDTH, one write port, one registered read port); FSM and arbiter remain in rtc_reg_sched.

Verification
REQ-031 v_sync=0, ed_req addr 4 data 0x12 -> ed_ack at cycle N+3, disp_addr 4 reads 0x12, upd_flags=3'b010.
REQ-032 v_sync=1, rtc_req addr 0 data 0x59 -> FSM holds WAIT_BLANK; v_sync->0 -> write, rtc_ack two cycles later; bank[0]=0x59.
REQ-033 rtc_req and ed_req both high from reset, addrs 1 and 7 -> ed serviced first, then rtc; acks never overlap; upd_flags=3'b101.
REQ-034 ed_req addr 12 data 0xAA -> ed_ack and err pulse together, bank unchanged, upd_flags unchanged.
REQ-035 reset=0 asserted during WAIT_BLANK with pending write 0x33 to addr 2 -> no ack, bank[2]=0x00, state IDLE.
REQ-036 upd_flags=3'b001, v_sync 0->1 -> flags 0 next cycle; write landing on the rising-edge cycle keeps its bit set.
